// File: rtl/eth_wbuf_pkg.sv
// eth_wbuf_pkg: read FSM states, write-buffer entry layout and packing helper
package eth_wbuf_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RD_ISSUE = 2'd1, RD_DONE = 2'd2} rd_state_e;
  localparam int WBUF_ENTRY_W = 66;
  localparam int DATA_LSB = 0;
  localparam int BE_LSB = 32;
  localparam int ADDR_LSB = 36;
  function automatic logic [WBUF_ENTRY_W-1:0] pack_entry(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    return {a, be, d};
  endfunction
endpackage

// File: rtl/eth_wbuf_fifo.sv
// eth_wbuf_fifo: synchronous FIFO of posted write entries
// Ports: clk, reset (sync, active-high); push/din write side; pop/head read side;
//        full, empty, level status. Pointers carry one extra wrap bit.
module eth_wbuf_fifo #(
  parameter int AW = 2,
  parameter int W = 66
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  end
  assign head = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign level = wp - rp;
endmodule

// File: rtl/eth_dma_wbuf_bridge.sv
// eth_dma_wbuf_bridge: posts MAC DMA writes into a buffer, orders reads behind them
// Ports: clk, reset (sync, active-high); s_* MAC-facing Avalon-MM slave;
//        m_* system-facing Avalon-MM master; wbuf_level buffer occupancy.
// Optional macro ETH_WBUF_STATS_EN adds stat_wr_stall and stat_rd_wait counters.
module eth_dma_wbuf_bridge
  import eth_wbuf_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       s_address,
  input  logic [3:0]        s_byteenable,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  output logic              s_waitrequest,
  output logic [29:0]       m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  input  logic              m_waitrequest,
`ifdef ETH_WBUF_STATS_EN
  output logic [15:0]       stat_wr_stall,
  output logic [15:0]       stat_rd_wait,
`endif
  output logic [FIFO_AW:0]  wbuf_level
);
  rd_state_e state, state_nx;
  logic push, pop, full, empty, start_read;
  logic [WBUF_ENTRY_W-1:0] din, head, src;
  assign din = pack_entry(s_address, s_byteenable, s_writedata);
  assign push = s_write & ~full & (state == IDLE);
  assign pop = m_write & ~m_waitrequest;
  assign start_read = (state == IDLE) & s_read & ~s_write & empty & ~m_write;
  // An empty buffer forwards the entry being pushed so m_write rises the next cycle.
  assign src = empty ? din : head;
  assign s_waitrequest = s_write ? ~push : (state != RD_DONE);
  assign m_read = (state == RD_ISSUE);
  eth_wbuf_fifo #(.AW(FIFO_AW), .W(WBUF_ENTRY_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .full(full),
    .empty(empty),
    .level(wbuf_level)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start_read ? RD_ISSUE : IDLE;
      RD_ISSUE: state_nx = m_waitrequest ? RD_ISSUE : RD_DONE;
      default:  state_nx = IDLE;
    endcase
  end
  // m_write drops for one cycle after each accept; the popped head is replaced then.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_write <= 1'b0;
      m_address <= '0;
      m_byteenable <= '0;
      m_writedata <= '0;
      s_readdata <= '0;
    end else begin
      if (m_write) m_write <= m_waitrequest;
      else if (!empty || push) begin
        m_write <= 1'b1;
        m_address <= src[ADDR_LSB +: 30];
        m_byteenable <= src[BE_LSB +: 4];
        m_writedata <= src[DATA_LSB +: 32];
      end else if (start_read) begin
        m_address <= s_address;
        m_byteenable <= s_byteenable;
      end
      if (state == RD_ISSUE && !m_waitrequest) s_readdata <= m_readdata;
    end
  end
`ifdef ETH_WBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_wr_stall <= '0;
      stat_rd_wait <= '0;
    end else begin
      if (s_write && full && stat_wr_stall != 16'hFFFF) stat_wr_stall <= stat_wr_stall + 16'd1;
      if (state == RD_ISSUE && m_waitrequest && stat_rd_wait != 16'hFFFF) stat_rd_wait <= stat_rd_wait + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_eth_dma_wbuf_bridge.sv
// tb_eth_dma_wbuf_bridge: scoreboard bench for the DMA write-buffer bridge
module tb_eth_dma_wbuf_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [29:0] s_address = '0;
  logic [3:0] s_byteenable = '0;
  logic s_read = 1'b0;
  logic s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic s_waitrequest;
  logic [29:0] m_address;
  logic [3:0] m_byteenable;
  logic m_read;
  logic m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic m_waitrequest = 1'b0;
  logic [2:0] wbuf_level;
  int n_cmp = 0;
  int n_err = 0;
  logic [65:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] mem [256];

  eth_dma_wbuf_bridge #(.FIFO_AW(2)) dut (
    .clk(clk),
    .reset(reset),
    .s_address(s_address),
    .s_byteenable(s_byteenable),
    .s_read(s_read),
    .s_write(s_write),
    .s_writedata(s_writedata),
    .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest),
    .m_address(m_address),
    .m_byteenable(m_byteenable),
    .m_read(m_read),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest),
    .wbuf_level(wbuf_level)
  );

  always #5 clk = ~clk;

  // System memory model; word 0x80 is a fixed ROM location.
  assign m_readdata = (m_address == 30'h80) ? 32'hCAFEF00D : mem[m_address[7:0]];

  always @(negedge clk) begin
    if (!reset) begin
      if (m_read && m_write) begin
        n_cmp++;
        n_err++;
        $display("FAIL rw_exclusive: m_read=%b m_write=%b, required not both high", m_read, m_write);
      end
      if (m_write && !m_waitrequest) begin
        logic [65:0] exp;
        n_cmp++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got %h/%h/%h, required no write", m_address, m_byteenable, m_writedata);
        end else begin
          exp = wq.pop_front();
          if ({m_address, m_byteenable, m_writedata} !== exp) begin
            n_err++;
            $display("FAIL wr_order: got %h, required %h", {m_address, m_byteenable, m_writedata}, exp);
          end
          for (int b = 0; b < 4; b++)
            if (m_byteenable[b]) mem[m_address[7:0]][8*b +: 8] = m_writedata[8*b +: 8];
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mac_write(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    bit ok = 0;
    s_write = 1'b1;
    s_address = a;
    s_byteenable = be;
    s_writedata = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = !s_waitrequest;
      if (ok) wq.push_back({a, be, d});
      tick();
    end
    s_write = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wr_accept: write to %h never accepted within 100 cycles", a);
    end
  endtask

  task automatic mac_read(input logic [29:0] a, output int lat);
    bit done = 0;
    bit early = 0;
    logic [31:0] exp;
    s_read = 1'b1;
    s_address = a;
    s_byteenable = 4'hF;
    lat = -1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (m_read && (m_write || wbuf_level != 0)) early = 1;
      if (!s_waitrequest) begin
        done = 1;
        lat = i;
        n_cmp++;
        exp = (rq.size() != 0) ? rq.pop_front() : 32'hxxxxxxxx;
        if (s_readdata !== exp) begin
          n_err++;
          $display("FAIL rd_data: got %h, required %h", s_readdata, exp);
        end
      end
      tick();
    end
    s_read = 1'b0;
    n_cmp++;
    if (!done || early) begin
      n_err++;
      $display("FAIL rd_order: done=%0d early=%0d, required done=1 early=0", done, early);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m_read, m_write, m_address, m_byteenable, m_writedata, s_readdata, wbuf_level, s_waitrequest}
        !== {1'b0, 1'b0, 30'd0, 4'd0, 32'd0, 32'd0, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: rd=%b wr=%b addr=%h be=%h wd=%h rdata=%h lvl=%0d wait=%b, required zeros and wait=1",
               m_read, m_write, m_address, m_byteenable, m_writedata, s_readdata, wbuf_level, s_waitrequest);
    end
    tick();
  endtask

  task automatic test_single_write;
    m_waitrequest = 1'b0;
    s_write = 1'b1;
    s_address = 30'h400;
    s_byteenable = 4'hF;
    s_writedata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if (s_waitrequest !== 1'b0) begin
      n_err++;
      $display("FAIL single_accept: s_waitrequest=%b, required 0", s_waitrequest);
    end
    wq.push_back({30'h400, 4'hF, 32'hDEADBEEF});
    tick();
    s_write = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m_write, m_address, m_byteenable, m_writedata} !== {1'b1, 30'h400, 4'hF, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL single_master: wr=%b addr=%h be=%h data=%h, required 1/400/f/deadbeef",
               m_write, m_address, m_byteenable, m_writedata);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (wbuf_level !== 3'd0 || m_write !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: level=%0d m_write=%b, required 0/0", wbuf_level, m_write);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    m_waitrequest = 1'b1;
    fork
      for (int k = 0; k < 6; k++) mac_write(30'h800 + 30'(k), 4'hF, 32'hA0000000 + 32'(k));
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (wbuf_level !== 3'd4 || s_waitrequest !== 1'b1 || wq.size() != 4) begin
          n_err++;
          $display("FAIL b2b_full: level=%0d wait=%b queued=%0d, required 4/1/4", wbuf_level, s_waitrequest, wq.size());
        end
        tick();
        m_waitrequest = 1'b0;
      end
    join
    for (int i = 0; i < 100 && (wq.size() != 0 || wbuf_level != 0 || m_write); i++) tick();
    n_cmp++;
    if (wq.size() != 0 || wbuf_level !== 3'd0) begin
      n_err++;
      $display("FAIL b2b_drain: pending=%0d level=%0d, required 0/0", wq.size(), wbuf_level);
    end
  endtask

  task automatic test_read_after_write;
    int lat;
    m_waitrequest = 1'b1;
    mac_write(30'h40, 4'hF, 32'h11111111);
    rq.push_back(32'h11111111);
    fork
      mac_read(30'h40, lat);
      begin
        repeat (3) tick();
        m_waitrequest = 1'b0;
      end
    join
    n_cmp++;
    if (lat <= 2 || wq.size() != 0) begin
      n_err++;
      $display("FAIL raw_latency: latency=%0d pending=%0d, required >2 and 0", lat, wq.size());
    end
  endtask

  task automatic test_read_nowait;
    int lat;
    m_waitrequest = 1'b0;
    rq.push_back(32'hCAFEF00D);
    mac_read(30'h80, lat);
    n_cmp++;
    if (lat != 2) begin
      n_err++;
      $display("FAIL rd_latency: got %0d cycles, required 2", lat);
    end
  endtask

  task automatic test_rw_same;
    bit saw_read = 0;
    m_waitrequest = 1'b0;
    s_read = 1'b1;
    mac_write(30'h50, 4'h3, 32'h12345678);
    s_read = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_read) saw_read = 1;
      tick();
    end
    n_cmp++;
    if (saw_read || wq.size() != 0) begin
      n_err++;
      $display("FAIL rw_same: saw_read=%0d pending=%0d, required 0/0", saw_read, wq.size());
    end
  endtask

  task automatic test_reset_mid;
    bit in_rd = 0;
    m_waitrequest = 1'b1;
    mac_write(30'h60, 4'hF, 32'h55555555);
    mac_write(30'h61, 4'hF, 32'h66666666);
    @(negedge clk);
    n_cmp++;
    if (wbuf_level !== 3'd2 || m_write !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre: level=%0d m_write=%b, required 2/1", wbuf_level, m_write);
    end
    tick();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || wbuf_level !== 3'd0) begin
      n_err++;
      $display("FAIL reset_wr: rd=%b wr=%b level=%0d, required 0/0/0", m_read, m_write, wbuf_level);
    end
    wq.delete();
    tick();
    reset = 1'b0;
    tick();
    s_read = 1'b1;
    s_address = 30'h70;
    for (int i = 0; i < 10 && !in_rd; i++) begin
      @(negedge clk);
      in_rd = m_read;
      tick();
    end
    reset = 1'b1;
    s_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (!in_rd || m_read !== 1'b0 || m_write !== 1'b0 || wbuf_level !== 3'd0) begin
      n_err++;
      $display("FAIL reset_rd: reached=%0d rd=%b wr=%b level=%0d, required 1/0/0/0", in_rd, m_read, m_write, wbuf_level);
    end
    tick();
    reset = 1'b0;
    m_waitrequest = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_after_write();
    test_read_nowait();
    test_rw_same();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
